// File: rtl/sifre_cozme_if.sv
// Bus bundle for the serial decipher block: framed serial input, key/mode
// selection, and the decoded word with its status strobes.
interface sifre_cozme_if #(
    parameter int BIT = 4
);
    logic           bit_girisi;
    logic           gecerli;
    logic           mod;
    logic [2:0]     secim;
    logic [BIT-1:0] veri_cikisi;
    logic           hazir;
    logic           hata;
    logic           mesgul;

    modport master (
        output bit_girisi, gecerli, mod, secim,
        input  veri_cikisi, hazir, hata, mesgul
    );

    modport slave (
        input  bit_girisi, gecerli, mod, secim,
        output veri_cikisi, hazir, hata, mesgul
    );
endinterface

// File: rtl/sifre_cozme.sv
// Serial LSB-first decipher (additive or XOR key) with frame abort detection.
// Optional even-parity slot after each frame: define SIFRE_PARITE_EN.
module sifre_cozme #(
    parameter int BIT = 4
) (
    input  logic          saat,
    input  logic          reset,
    sifre_cozme_if.slave  bus
);
    typedef enum logic [1:0] {BEKLE, ALIM, TAMAM} durum_t;

    localparam int unsigned CW = $clog2(BIT + 2);
`ifdef SIFRE_PARITE_EN
    localparam logic [CW-1:0] SON = CW'(BIT);
`else
    localparam logic [CW-1:0] SON = CW'(BIT - 1);
`endif

    durum_t         durum, durum_n;
    logic [CW-1:0]  sayac;
    logic [BIT-1:0] kaydirici;
    logic           mod_r;
    logic [2:0]     secim_r;
    logic [BIT-1:0] veri_r;
    logic           hazir_r, hata_r;

    logic           basla, kaydir, bitti, iptal, mesgul_c;
    logic           parite_ok;
    logic [BIT-1:0] sifreli, duz, anahtar_x, anahtar_t;

    // Without parity the last ciphertext bit is still on the wire when the
    // word is decoded, so it is merged in combinationally for 1-cycle latency.
    always_comb begin
        anahtar_x = BIT'({BIT{secim_r}});
        anahtar_t = BIT'(secim_r);
`ifdef SIFRE_PARITE_EN
        sifreli   = kaydirici;
        parite_ok = ((^kaydirici) == bus.bit_girisi);
`else
        sifreli   = BIT'({bus.bit_girisi, kaydirici} >> 1);
        parite_ok = 1'b1;
`endif
        duz = mod_r ? (sifreli ^ anahtar_x) : (sifreli - anahtar_t);
    end

    always_ff @(posedge saat) begin
        if (reset) durum <= BEKLE;
        else       durum <= durum_n;
    end

    always_comb begin
        durum_n  = durum;
        basla    = 1'b0;
        kaydir   = 1'b0;
        bitti    = 1'b0;
        iptal    = 1'b0;
        mesgul_c = 1'b0;
        case (durum)
            BEKLE: begin
                if (bus.gecerli) begin
                    basla   = 1'b1;
                    durum_n = ALIM;
                end
            end
            ALIM: begin
                mesgul_c = 1'b1;
                if (!bus.gecerli) begin
                    iptal   = 1'b1;
                    durum_n = BEKLE;
                end else if (sayac == SON) begin
                    bitti   = 1'b1;
                    durum_n = TAMAM;
                end else begin
                    kaydir  = 1'b1;
                end
            end
            TAMAM: begin
                if (bus.gecerli) begin
                    basla    = 1'b1;
                    mesgul_c = 1'b1;
                    durum_n  = ALIM;
                end else begin
                    durum_n  = BEKLE;
                end
            end
            default: durum_n = BEKLE;
        endcase
    end

    always_ff @(posedge saat) begin
        if (reset) begin
            sayac     <= '0;
            kaydirici <= '0;
            mod_r     <= 1'b0;
            secim_r   <= '0;
            veri_r    <= '0;
            hazir_r   <= 1'b0;
            hata_r    <= 1'b0;
        end else begin
            hazir_r <= 1'b0;
            hata_r  <= 1'b0;
            if (basla) begin
                kaydirici <= {bus.bit_girisi, kaydirici[BIT-1:1]};
                sayac     <= CW'(1);
                mod_r     <= bus.mod;
                secim_r   <= bus.secim;
            end
            if (kaydir) begin
                kaydirici <= {bus.bit_girisi, kaydirici[BIT-1:1]};
                sayac     <= sayac + 1'b1;
            end
            if (bitti) begin
                if (parite_ok) begin
                    veri_r  <= duz;
                    hazir_r <= 1'b1;
                end else begin
                    hata_r  <= 1'b1;
                end
            end
            if (iptal) hata_r <= 1'b1;
        end
    end

    assign bus.veri_cikisi = veri_r;
    assign bus.hazir       = hazir_r;
    assign bus.hata        = hata_r;
    assign bus.mesgul      = mesgul_c;
endmodule

// File: tb/tb_sifre_cozme.sv
// Self-checking bench for sifre_cozme: directed vector table, hand-written
// corner sequences and randomized frames against an arithmetic reference.
module tb_sifre_cozme;
    localparam int BIT = 4;
`ifdef SIFRE_PARITE_EN
    localparam int NSLOT = BIT + 1;
`else
    localparam int NSLOT = BIT;
`endif

    logic saat  = 1'b0;
    logic reset = 1'b1;

    sifre_cozme_if #(.BIT(BIT)) bus ();
    sifre_cozme #(.BIT(BIT)) dut (.saat(saat), .reset(reset), .bus(bus));

    always #5 saat = ~saat;

    int n_err = 0;
    int n_chk = 0;
    logic [BIT-1:0] exp_q = '0;

    typedef struct {
        int c;
        int m;
        int s;
        int e;
    } vec_t;
    vec_t tbl [8];

    function automatic logic [BIT-1:0] ref_plain(logic [BIT-1:0] c, bit m, logic [2:0] s);
        int ci = int'(c);
        int si = int'(s);
        int k  = 0;
        if (!m) return BIT'((ci - si + (1 << BIT)) % (1 << BIT));
        for (int i = 0; i < BIT; i++)
            if (((si >> (i % 3)) & 1) == 1) k = k | (1 << i);
        return BIT'(ci ^ k);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge saat);
        #1;
    endtask

    task automatic drive_slot(input bit v, input bit b, input bit m, input logic [2:0] s);
        bus.gecerli    = v;
        bus.bit_girisi = b;
        bus.mod        = m;
        bus.secim      = s;
    endtask

    // Drives nslots frame slots; mode/key are scrambled after slot 0.
    task automatic send_bits(input logic [BIT-1:0] cv, input bit m, input logic [2:0] s,
                             input int nslots, input bit flip);
        for (int i = 0; i < nslots; i++) begin
            bit b;
            if (i < BIT) b = cv[i];
            else         b = (^cv) ^ flip;
            if (i == 0) drive_slot(1'b1, b, m, s);
            else        drive_slot(1'b1, b, 1'($urandom), 3'($urandom));
            tick;
            if (i < NSLOT - 1) begin
                chk("hazir_mid",  int'(bus.hazir),  0);
                chk("hata_mid",   int'(bus.hata),   0);
                chk("mesgul_mid", int'(bus.mesgul), 1);
            end
        end
    endtask

    task automatic frame_ok(input logic [BIT-1:0] cv, input bit m, input logic [2:0] s);
        send_bits(cv, m, s, NSLOT, 1'b0);
        exp_q = ref_plain(cv, m, s);
        chk("hazir_done", int'(bus.hazir), 1);
        chk("hata_done",  int'(bus.hata),  0);
        chk("veri_done",  int'(bus.veri_cikisi), int'(exp_q));
    endtask

    task automatic idle(input int n);
        drive_slot(1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
        for (int i = 0; i < n; i++) begin
            tick;
            chk("hazir_idle",  int'(bus.hazir),  0);
            chk("hata_idle",   int'(bus.hata),   0);
            chk("mesgul_idle", int'(bus.mesgul), 0);
            chk("veri_idle",   int'(bus.veri_cikisi), int'(exp_q));
        end
    endtask

    task automatic abort_at(input int k, input logic [BIT-1:0] cv, input bit m, input logic [2:0] s);
        send_bits(cv, m, s, k, 1'b0);
        drive_slot(1'b0, 1'b0, m, s);
        tick;
        chk("hata_abort",   int'(bus.hata),   1);
        chk("hazir_abort",  int'(bus.hazir),  0);
        chk("mesgul_abort", int'(bus.mesgul), 0);
        chk("veri_abort",   int'(bus.veri_cikisi), int'(exp_q));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{12, 0, 3,  9};
        tbl[1] = '{ 1, 1, 4,  5};
        tbl[2] = '{ 7, 1, 2,  5};
        tbl[3] = '{ 6, 0, 0,  6};
        tbl[4] = '{ 0, 0, 1, 15};
        tbl[5] = '{15, 1, 7,  0};
        tbl[6] = '{ 5, 0, 7, 14};
        tbl[7] = '{ 3, 1, 1, 10};

        // reset held for two cycles, then released
        drive_slot(1'b0, 1'b0, 1'b0, 3'd0);
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        tick;
        chk("rst_veri",   int'(bus.veri_cikisi), 0);
        chk("rst_hazir",  int'(bus.hazir),  0);
        chk("rst_hata",   int'(bus.hata),   0);
        chk("rst_mesgul", int'(bus.mesgul), 0);

        foreach (tbl[i]) begin
            frame_ok(BIT'(tbl[i].c), bit'(tbl[i].m), 3'(tbl[i].s));
            chk("tbl_veri", int'(bus.veri_cikisi), tbl[i].e);
            idle(1);
        end

        // back-to-back frames, second starts in the TAMAM cycle
        frame_ok(BIT'(1), 1'b1, 3'd4);
        chk("b2b_first", int'(bus.veri_cikisi), 5);
        drive_slot(1'b1, 1'b1, 1'b1, 3'd2);
        #1;
        chk("b2b_mesgul", int'(bus.mesgul), 1);
        frame_ok(BIT'(7), 1'b1, 3'd2);
        chk("b2b_second", int'(bus.veri_cikisi), 5);
        idle(2);

        // abort after two bits keeps the previous word
        abort_at(2, BIT'(10), 1'b0, 3'd1);
        chk("abort_keep", int'(bus.veri_cikisi), 5);
        idle(1);

        // reset after the third bit: no strobes, word cleared
        send_bits(BIT'(9), 1'b0, 3'd1, 3, 1'b0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        drive_slot(1'b0, 1'b0, 1'b0, 3'd0);
        exp_q = '0;
        chk("mrst_hazir",  int'(bus.hazir),  0);
        chk("mrst_hata",   int'(bus.hata),   0);
        chk("mrst_mesgul", int'(bus.mesgul), 0);
        idle(2);
        frame_ok(BIT'(6), 1'b0, 3'd0);
        chk("mrst_next", int'(bus.veri_cikisi), 6);
        idle(1);

`ifdef SIFRE_PARITE_EN
        frame_ok(BIT'(12), 1'b0, 3'd3);
        chk("par_good", int'(bus.veri_cikisi), 9);
        idle(1);
        send_bits(BIT'(12), 1'b0, 3'd3, NSLOT, 1'b1);
        chk("par_bad_hata",  int'(bus.hata),  1);
        chk("par_bad_hazir", int'(bus.hazir), 0);
        chk("par_bad_veri",  int'(bus.veri_cikisi), 9);
        idle(1);
        abort_at(BIT, BIT'(3), 1'b1, 3'd5);
        idle(1);
`endif

        for (int n = 0; n < 80; n++) begin
            logic [BIT-1:0] cv = BIT'($urandom);
            bit             m  = 1'($urandom);
            logic [2:0]     s  = 3'($urandom);
            int             sel = int'($urandom_range(0, 7));
            int             gap = int'($urandom_range(0, 2));
            if (sel == 0) begin
                abort_at(int'($urandom_range(1, NSLOT - 1)), cv, m, s);
            end
`ifdef SIFRE_PARITE_EN
            else if (sel == 1) begin
                send_bits(cv, m, s, NSLOT, 1'b1);
                chk("rnd_par_hata",  int'(bus.hata),  1);
                chk("rnd_par_hazir", int'(bus.hazir), 0);
                chk("rnd_par_veri",  int'(bus.veri_cikisi), int'(exp_q));
            end
`endif
            else begin
                frame_ok(cv, m, s);
            end
            if (gap > 0) idle(gap);
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
